ca_code_chip_gen: RTL and testbench
===================================

// Module: ca_code_chip_gen
// PURPOSE
//  GPS L1 C/A chip generator, downstream of code_phase_to_lfsr. Loads G1/G2 LFSR
//  states for a code phase and steps both registers once per chip_en strobe.
//  Outputs the PRN chip, the running code phase and a 1 ms epoch strobe.
//  Feeds the correlator/replica mixer in the acquisition datapath.
// PARAMETERS
//  CODE_LEN  1023  chips per code period; phase counter wraps CODE_LEN-1 -> 0
//  PRN_W     6     width of prn select input
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous active-low reset
//  load        in   1      1-cycle strobe: capture g1_in/g2_in/phase_in/prn
//  g1_in       in   10     G1 state for phase_in (from code_phase_to_lfsr.g1)
//  g2_in       in   10     G2 state for phase_in (from code_phase_to_lfsr.g2)
//  phase_in    in   10     code phase matching g1_in/g2_in, 0..1022
//  prn         in   PRN_W  satellite PRN 1..32, sampled on load only
//  chip_en     in   1      advance one chip this cycle
//  chip        out  1      current C/A chip (1 = logic one)
//  chip_valid  out  1      chip/phase_out meaningful (state RUN, prn legal)
//  phase_out   out  10     phase index of current chip
//  epoch       out  1      1-cycle pulse when phase_out wraps to 0
//  prn_err     out  1      sticky: last load carried prn 0 or >32
// BEHAVIOUR
//  - Bit k-1 holds LFSR stage k. Shift: stage1 <= feedback, stage k+1 <= stage k.
//    G1 fb = g1[2]^g1[9]; G2 fb = g2[1]^g2[2]^g2[5]^g2[7]^g2[8]^g2[9].
//  - chip = g1[9] ^ g2[s1-1] ^ g2[s2-1]; (s1,s2) from the IS-GPS-200 PRN tap
//    table (PRN1 = 2,6; PRN2 = 3,7; ... PRN32 = 4,9). Taps latched at load.
//  - Reset: g1=g2=10'h3FF, phase_out=0, chip=0, chip_valid=0, epoch=0, prn_err=0, FSM IDLE.
//  - FSM IDLE: chip_en ignored; load -> RUN. RUN: load re-captures and stays RUN.
//  - Latency: load at edge n -> registers/outputs reflect phase_in after edge n;
//    chip_en at edge n -> next chip/phase visible after edge n. Chip is registered.
//  - Phase: chip_en in RUN increments phase_out; at CODE_LEN-1 wraps to 0, asserts
//    epoch for exactly one cycle coinciding with phase_out==0. Both LFSRs are
//    reloaded with 10'h3FF on wrap (not shifted) to guarantee period alignment.
//  - load and chip_en same cycle: load wins, chip_en dropped, no epoch.
//  - load with phase_in==0 does not assert epoch. phase_in >= CODE_LEN: clamp
//    capture to 0 with all-ones LFSRs.
//  - Illegal prn: enters RUN, counter runs, chip forced 0, chip_valid=0, prn_err=1;
//    prn_err cleared by next legal load or reset.
//  - rst asserted mid-run: immediate return to reset values, epoch drops asynchronously.
// CONFIGURATION
//  CA_EPOCH_CNT_EN defined: adds output epoch_cnt[4:0], counts epochs 0..19,
//    wraps 19->0, output bit_edge pulses with epoch when count wraps to 0
//    (50 bps nav bit boundary); cleared by reset and by load.
//  Undefined: no epoch_cnt/bit_edge ports, no counter logic.
// TESTING
//  1 PRN1, load g1=g2=3FF phase 0, 10 chip_en -> chips 1,1,0,0,1,0,0,0,0,0 (octal 1440).
//  2 PRN1 from phase 0, 1023 chip_en -> epoch exactly once, phase_out 0, chip
//    sequence equals golden C/A table; second period identical.
//  3 Load phase 1022 with upstream states, 1 chip_en -> phase_out 0, epoch=1 one
//    cycle, g1=g2=3FF; chip matches golden chip 0.
//  4 load and chip_en asserted same cycle at phase 500 -> phase_out=500, no advance.
//  5 prn=0 load -> chip_valid=0, chip=0, prn_err=1; then prn=5 load -> prn_err=0.
//  6 rst low mid-run at phase 300 -> all outputs reset values, chip_en ignored
//    until next load; CA_EPOCH_CNT_EN build: 20 epochs -> one bit_edge.

Source files
------------

// File: rtl/ca_code_chip_gen.sv
// GPS L1 C/A chip generator: G1/G2 LFSRs loaded per code phase, stepped on chip_en.
// Optional epoch counter / nav bit edge output enabled by CA_EPOCH_CNT_EN.
module ca_code_chip_gen #(
  parameter int unsigned CODE_LEN = 1023,
  parameter int unsigned PRN_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [9:0]       g1_in,
  input  logic [9:0]       g2_in,
  input  logic [9:0]       phase_in,
  input  logic [PRN_W-1:0] prn,
  input  logic             chip_en,
  output logic             chip,
  output logic             chip_valid,
  output logic [9:0]       phase_out,
  output logic             epoch,
  output logic             prn_err
`ifdef CA_EPOCH_CNT_EN
  ,
  output logic [4:0]       epoch_cnt,
  output logic             bit_edge
`endif
);

  localparam int unsigned LW = 10;
  localparam int unsigned TW = 4;
  localparam logic [LW-1:0] PH_LAST  = LW'(CODE_LEN - 1);
  localparam logic [LW-1:0] ALL_ONES = '1;
  localparam logic [LW-1:0] G2_FB    = 10'b11_1010_0110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [LW-1:0] g1, g2;
  logic [TW-1:0] s1, s2;
  logic          prn_ok;

  logic [LW-1:0] g1_nx, g2_nx, ph_nx;
  logic [TW-1:0] s1_nx, s2_nx;
  logic          ok_nx, upd, wrap, legal, chip_nx;
  logic [7:0]    taps;

  // G2 tap pair (zero-based stage indices) for each PRN, IS-GPS-200 table
  function automatic logic [7:0] prn_taps(input logic [PRN_W-1:0] p);
    case (int'(p))
      1: return 8'h15;  2: return 8'h26;  3: return 8'h37;  4: return 8'h48;
      5: return 8'h08;  6: return 8'h19;  7: return 8'h07;  8: return 8'h18;
      9: return 8'h29; 10: return 8'h12; 11: return 8'h23; 12: return 8'h45;
     13: return 8'h56; 14: return 8'h67; 15: return 8'h78; 16: return 8'h89;
     17: return 8'h03; 18: return 8'h14; 19: return 8'h25; 20: return 8'h36;
     21: return 8'h47; 22: return 8'h58; 23: return 8'h02; 24: return 8'h35;
     25: return 8'h46; 26: return 8'h57; 27: return 8'h68; 28: return 8'h79;
     29: return 8'h05; 30: return 8'h16; 31: return 8'h27; 32: return 8'h38;
      default: return 8'h00;
    endcase
  endfunction

  // Next LFSR/phase state: load has priority over chip_en; wrap realigns to all-ones
  always_comb begin
    g1_nx = g1;
    g2_nx = g2;
    ph_nx = phase_out;
    s1_nx = s1;
    s2_nx = s2;
    ok_nx = prn_ok;
    upd   = 1'b0;
    wrap  = 1'b0;
    legal = (int'(prn) >= 1) && (int'(prn) <= 32);
    taps  = prn_taps(prn);
    if (load) begin
      upd   = 1'b1;
      s1_nx = taps[7:4];
      s2_nx = taps[3:0];
      ok_nx = legal;
      if (phase_in > PH_LAST) begin
        g1_nx = ALL_ONES;
        g2_nx = ALL_ONES;
        ph_nx = '0;
      end else begin
        g1_nx = g1_in;
        g2_nx = g2_in;
        ph_nx = phase_in;
      end
    end else if (state == RUN && chip_en) begin
      upd = 1'b1;
      if (phase_out == PH_LAST) begin
        wrap  = 1'b1;
        g1_nx = ALL_ONES;
        g2_nx = ALL_ONES;
        ph_nx = '0;
      end else begin
        g1_nx = {g1[8:0], g1[2] ^ g1[9]};
        g2_nx = {g2[8:0], ^(g2 & G2_FB)};
        ph_nx = phase_out + LW'(1);
      end
    end
    chip_nx = ok_nx & (g1_nx[9] ^ g2_nx[s1_nx] ^ g2_nx[s2_nx]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      g1         <= ALL_ONES;
      g2         <= ALL_ONES;
      s1         <= '0;
      s2         <= '0;
      prn_ok     <= 1'b0;
      phase_out  <= '0;
      chip       <= 1'b0;
      chip_valid <= 1'b0;
      epoch      <= 1'b0;
      prn_err    <= 1'b0;
    end else begin
      if (load) state <= RUN;
      if (upd) begin
        g1        <= g1_nx;
        g2        <= g2_nx;
        phase_out <= ph_nx;
        chip      <= chip_nx;
      end
      s1         <= s1_nx;
      s2         <= s2_nx;
      prn_ok     <= ok_nx;
      chip_valid <= ok_nx & (load | (state == RUN));
      epoch      <= wrap;
      if (load) prn_err <= ~legal;
    end
  end

`ifdef CA_EPOCH_CNT_EN
  // Twenty code epochs per 50 bps navigation bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epoch_cnt <= '0;
      bit_edge  <= 1'b0;
    end else if (load) begin
      epoch_cnt <= '0;
      bit_edge  <= 1'b0;
    end else if (wrap) begin
      if (epoch_cnt == 5'd19) begin
        epoch_cnt <= '0;
        bit_edge  <= 1'b1;
      end else begin
        epoch_cnt <= epoch_cnt + 5'd1;
        bit_edge  <= 1'b0;
      end
    end else begin
      bit_edge <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ca_code_chip_gen.sv
// Bench for ca_code_chip_gen: directed + random steps against a Gold-code sequence model.
module tb_ca_code_chip_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [9:0] g1_in = '0, g2_in = '0, phase_in = '0;
  logic [5:0] prn = '0;
  logic       chip_en = 1'b0;
  logic       chip, chip_valid, epoch, prn_err;
  logic [9:0] phase_out;
`ifdef CA_EPOCH_CNT_EN
  logic [4:0] epoch_cnt;
  logic       bit_edge;
`endif

  ca_code_chip_gen dut (
    .clk(clk), .rst(rst), .load(load), .g1_in(g1_in), .g2_in(g2_in),
    .phase_in(phase_in), .prn(prn), .chip_en(chip_en), .chip(chip),
    .chip_valid(chip_valid), .phase_out(phase_out), .epoch(epoch), .prn_err(prn_err)
`ifdef CA_EPOCH_CNT_EN
    , .epoch_cnt(epoch_cnt), .bit_edge(bit_edge)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // f1/f2: stage-1 history of each LFSR, index i = time + 9, all ones before time 1
  bit f1 [0:1032];
  bit f2 [0:1032];
  int s1_tab [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int s2_tab [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  int  m_phase = 0, m_prn = 0;
  bit  m_ok = 0, m_run = 0, m_err = 0, m_epoch = 0;

  function automatic bit gold(int p, int t);
    return f1[t] ^ f2[t + 10 - s1_tab[p-1]] ^ f2[t + 10 - s2_tab[p-1]];
  endfunction

  function automatic logic [9:0] st1(int t);
    logic [9:0] v;
    for (int k = 1; k <= 10; k++) v[k-1] = f1[t + 10 - k];
    return v;
  endfunction

  function automatic logic [9:0] st2(int t);
    logic [9:0] v;
    for (int k = 1; k <= 10; k++) v[k-1] = f2[t + 10 - k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic verify(input string tag);
    bit v;
    v = m_run && m_ok;
    chk({tag, ".phase"}, 32'(phase_out), 32'(m_phase));
    chk({tag, ".epoch"}, 32'(epoch), 32'(m_epoch));
    chk({tag, ".valid"}, 32'(chip_valid), 32'(v));
    chk({tag, ".chip"}, 32'(chip), v ? 32'(gold(m_prn, m_phase)) : 32'd0);
    chk({tag, ".prn_err"}, 32'(prn_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input int p, input int ph, input bit en);
    load = 1'b1; prn = 6'(p); chip_en = en; phase_in = 10'(ph);
    if (ph < 1023) begin g1_in = st1(ph); g2_in = st2(ph); end
    else begin g1_in = 10'($urandom); g2_in = 10'($urandom); end
    tick();
    load = 1'b0; chip_en = 1'b0;
    m_prn = p; m_ok = (p >= 1 && p <= 32); m_err = !m_ok; m_run = 1;
    m_phase = (ph < 1023) ? ph : 0; m_epoch = 0;
    verify("load");
  endtask

  task automatic adv(input bit en, input string tag);
    chip_en = en;
    tick();
    chip_en = 1'b0;
    if (m_run && en) begin
      m_epoch = (m_phase == 1022);
      m_phase = (m_phase + 1) % 1023;
    end else m_epoch = 0;
    verify(tag);
  endtask

  task automatic reset_model();
    m_phase = 0; m_run = 0; m_ok = 0; m_err = 0; m_epoch = 0;
  endtask

  initial begin
    logic [9:0] first10;
    int ep;
    for (int i = 0; i < 10; i++) begin f1[i] = 1; f2[i] = 1; end
    for (int i = 10; i <= 1032; i++) begin
      f1[i] = f1[i-3] ^ f1[i-10];
      f2[i] = f2[i-2] ^ f2[i-3] ^ f2[i-6] ^ f2[i-8] ^ f2[i-9] ^ f2[i-10];
    end

    // reset state and IDLE ignoring chip_en
    #12;
    reset_model();
    verify("reset");
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) adv(1'b1, "idle");

    // PRN1 from phase 0: first ten chips, then two full periods
    load_op(1, 0, 1'b0);
    first10 = 10'(chip);
    for (int i = 0; i < 9; i++) begin
      adv(1'b1, "prn1");
      first10 = {first10[8:0], chip};
    end
    chk("octal1440", 32'(first10), 32'o1440);
    ep = 0;
    for (int i = 0; i < 2046 - 9; i++) begin
      adv(1'b1, "period");
      ep += int'(epoch);
    end
    chk("epochs2", 32'(ep), 32'd2);
    chk("period_end_phase", 32'(phase_out), 32'd0);

    // wrap from 1022 with upstream states
    load_op(7, 1022, 1'b0);
    adv(1'b1, "wrap");
    chk("wrap_epoch", 32'(epoch), 32'd1);
    adv(1'b0, "wrap_hold");
    adv(1'b1, "wrap_next");

    // load and chip_en together, clamp of out-of-range phase
    load_op(13, 500, 1'b1);
    chk("load_wins", 32'(phase_out), 32'd500);
    load_op(20, 1023, 1'b0);
    load_op(20, 1000, 1'b0);
    adv(1'b1, "after_clamp");

    // illegal PRNs then a legal reload
    load_op(0, 100, 1'b0);
    for (int i = 0; i < 4; i++) adv(1'b1, "prn0");
    load_op(40, 1021, 1'b0);
    for (int i = 0; i < 4; i++) adv(1'b1, "prn40");
    load_op(5, 200, 1'b0);
    adv(1'b1, "prn5");

    // randomized runs with sparse chip_en and occasional reloads
    for (int r = 0; r < 6; r++) begin
      load_op(int'($urandom_range(32, 1)), int'($urandom_range(1022, 0)), 1'(r & 1));
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(99, 0) == 0)
          load_op(int'($urandom_range(32, 1)), int'($urandom_range(1022, 900)), 1'($urandom));
        else
          adv(1'($urandom_range(3, 0) != 0), "rand");
      end
    end

    // asynchronous reset while epoch is high
    load_op(9, 1022, 1'b0);
    adv(1'b1, "pre_rst");
    #2 rst = 1'b0;
    #1 reset_model();
    verify("rst_epoch");
    #2 rst = 1'b1;

    // asynchronous reset mid-run at phase 300
    load_op(3, 290, 1'b0);
    for (int i = 0; i < 10; i++) adv(1'b1, "to300");
    chk("at300", 32'(phase_out), 32'd300);
    #2 rst = 1'b0;
    #1 reset_model();
    verify("rst_mid");
    adv(1'b1, "rst_low");
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) adv(1'b1, "post_rst_idle");
    load_op(3, 0, 1'b0);
    adv(1'b1, "post_rst_run");

`ifdef CA_EPOCH_CNT_EN
    // twenty epochs produce exactly one nav bit edge
    load_op(1, 0, 1'b0);
    chk("ecnt_load", 32'(epoch_cnt), 32'd0);
    begin
      int edges, eps;
      edges = 0; eps = 0;
      for (int i = 0; i < 20 * 1023; i++) begin
        chip_en = 1'b1;
        tick();
        eps += int'(epoch);
        edges += int'(bit_edge);
        if (bit_edge && !epoch) chk("edge_with_epoch", 32'(epoch), 32'd1);
      end
      chip_en = 1'b0;
      chk("epochs20", 32'(eps), 32'd20);
      chk("bit_edges", 32'(edges), 32'd1);
      chk("ecnt_wrap", 32'(epoch_cnt), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
